// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: staged reset sequencer, run-cycle budget monitor and branch-predictor event counters
module sim_run_ctrl #(
    parameter int NUM_DOMAINS  = 2,
    parameter int RESET_CYCLES = 2,
    parameter int STAGE_GAP    = 1,
    parameter int MAX_CYCLES   = 200,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   halt_i,
    input  logic                   retire_i,
    input  logic                   branch_i,
    input  logic                   mispredict_i,
    output logic [NUM_DOMAINS-1:0] dom_reset_o,
    output logic                   running_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [CNT_W-1:0]       cycle_cnt_o,
    output logic [CNT_W-1:0]       retire_cnt_o,
    output logic [CNT_W-1:0]       branch_cnt_o,
    output logic [CNT_W-1:0]       mispred_cnt_o
);

    typedef enum logic [2:0] {HOLD, SEQ, RUN, DONE, TIMEOUT} state_t;

    state_t                 state, state_n;
    logic [31:0]            phase, phase_n;
    logic [NUM_DOMAINS-1:0] dom, dom_n;
    logic [CNT_W-1:0]       cyc, cyc_n, ret, ret_n, br, br_n, mp, mp_n;

    // Next state: hold/gap timing shares one phase counter; each release shifts a zero into the domain mask from bit 0
    always_comb begin
        state_n = state;
        phase_n = phase;
        dom_n   = dom;
        cyc_n   = cyc;
        ret_n   = ret;
        br_n    = br;
        mp_n    = mp;
        case (state)
            HOLD: begin
                phase_n = phase + 32'd1;
                if (phase == 32'(RESET_CYCLES - 1)) begin
                    phase_n = '0;
                    dom_n   = dom << 1;
                    state_n = (NUM_DOMAINS == 1) ? RUN : SEQ;
                end
            end
            SEQ: begin
                phase_n = phase + 32'd1;
                if (phase == 32'(STAGE_GAP - 1)) begin
                    phase_n = '0;
                    dom_n   = dom << 1;
                    state_n = (dom_n == '0) ? RUN : SEQ;
                end
            end
            RUN: begin
                cyc_n   = cyc + CNT_W'(1);
                ret_n   = ret + CNT_W'(retire_i);
                br_n    = br + CNT_W'(branch_i);
                mp_n    = mp + CNT_W'(branch_i & mispredict_i);
                state_n = halt_i ? DONE : (cyc_n == CNT_W'(MAX_CYCLES)) ? TIMEOUT : RUN;
            end
            default: ;
        endcase
    end

    // State and counter registers; reset returns everything to the start of the release sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HOLD;
            phase <= '0;
            dom   <= '1;
            cyc   <= '0;
            ret   <= '0;
            br    <= '0;
            mp    <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            dom   <= dom_n;
            cyc   <= cyc_n;
            ret   <= ret_n;
            br    <= br_n;
            mp    <= mp_n;
        end
    end

    assign dom_reset_o   = dom;
    assign running_o     = state == RUN;
    assign done_o        = state == DONE;
    assign timeout_o     = state == TIMEOUT;
    assign cycle_cnt_o   = cyc;
    assign retire_cnt_o  = ret;
    assign branch_cnt_o  = br;
    assign mispred_cnt_o = mp;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: scoreboard bench driving a default and a 4-domain controller from shared random stimulus
module tb_sim_run_ctrl;

    localparam int MAXC = 200;

    logic clk = 0, reset = 1, halt_i = 0, retire_i = 0, branch_i = 0, mispredict_i = 0;
    logic [1:0]  dom_a;
    logic [3:0]  dom_b;
    logic        run_a, done_a, to_a, run_b, done_b, to_b;
    logic [31:0] cyc_a, ret_a, br_a, mp_a, cyc_b, ret_b, br_b, mp_b;

    always #5 clk = ~clk;

    sim_run_ctrl u_a (
        .clk(clk), .reset(reset), .halt_i(halt_i), .retire_i(retire_i), .branch_i(branch_i),
        .mispredict_i(mispredict_i), .dom_reset_o(dom_a), .running_o(run_a), .done_o(done_a),
        .timeout_o(to_a), .cycle_cnt_o(cyc_a), .retire_cnt_o(ret_a), .branch_cnt_o(br_a),
        .mispred_cnt_o(mp_a)
    );

    sim_run_ctrl #(.NUM_DOMAINS(4), .RESET_CYCLES(3), .STAGE_GAP(2), .MAX_CYCLES(MAXC), .CNT_W(32)) u_b (
        .clk(clk), .reset(reset), .halt_i(halt_i), .retire_i(retire_i), .branch_i(branch_i),
        .mispredict_i(mispredict_i), .dom_reset_o(dom_b), .running_o(run_b), .done_o(done_b),
        .timeout_o(to_b), .cycle_cnt_o(cyc_b), .retire_cnt_o(ret_b), .branch_cnt_o(br_b),
        .mispred_cnt_o(mp_b)
    );

    typedef struct {
        logic [3:0]  dom;
        logic        run, done, to;
        logic [31:0] cyc, ret, br, mp;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t xa, xb;
    int vectors = 0, miscompares = 0;

    int nd[2] = '{2, 4};
    int rc[2] = '{2, 3};
    int sg[2] = '{1, 2};
    int e[2], st[2], cyc[2], ret[2], br[2], mp[2];

    // Reference: st 0 = releasing (e edges since reset), 1 = run, 2 = done, 3 = timeout
    task automatic model_step(input int k, input logic r, h, rt, b, m, output exp_t x);
        if (r) begin
            e[k] = 0; st[k] = 0; cyc[k] = 0; ret[k] = 0; br[k] = 0; mp[k] = 0;
        end else if (st[k] == 0) begin
            e[k]++;
            if (e[k] == rc[k] + (nd[k] - 1) * sg[k]) st[k] = 1;
        end else if (st[k] == 1) begin
            cyc[k]++;
            ret[k] += int'(rt);
            br[k]  += int'(b);
            mp[k]  += int'(b & m);
            if (h) st[k] = 2;
            else if (cyc[k] == MAXC) st[k] = 3;
        end
        x.dom = '0;
        for (int i = 0; i < nd[k]; i++) x.dom[i] = (st[k] == 0) && (e[k] < rc[k] + i * sg[k]);
        x.run  = st[k] == 1;
        x.done = st[k] == 2;
        x.to   = st[k] == 3;
        x.cyc  = cyc[k];
        x.ret  = ret[k];
        x.br   = br[k];
        x.mp   = mp[k];
    endtask

    task automatic step(input logic r, h, rt, b, m);
        exp_t x;
        reset = r; halt_i = h; retire_i = rt; branch_i = b; mispredict_i = m;
        @(posedge clk);
        model_step(0, r, h, rt, b, m, x);
        qa.push_back(x);
        model_step(1, r, h, rt, b, m, x);
        qb.push_back(x);
        #1;
    endtask

    function automatic logic rb(input int p);
        return $urandom_range(p - 1) == 0;
    endfunction

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endfunction

    // Monitor: each edge's expected outputs are popped and compared half a cycle later
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            xa = qa.pop_front();
            vectors++;
            chk("a.dom_reset", {30'd0, dom_a}, {28'd0, xa.dom});
            chk("a.running", {31'd0, run_a}, {31'd0, xa.run});
            chk("a.done", {31'd0, done_a}, {31'd0, xa.done});
            chk("a.timeout", {31'd0, to_a}, {31'd0, xa.to});
            chk("a.cycle_cnt", cyc_a, xa.cyc);
            chk("a.retire_cnt", ret_a, xa.ret);
            chk("a.branch_cnt", br_a, xa.br);
            chk("a.mispred_cnt", mp_a, xa.mp);
        end
        if (qb.size() > 0) begin
            xb = qb.pop_front();
            vectors++;
            chk("b.dom_reset", {28'd0, dom_b}, {28'd0, xb.dom});
            chk("b.running", {31'd0, run_b}, {31'd0, xb.run});
            chk("b.done", {31'd0, done_b}, {31'd0, xb.done});
            chk("b.timeout", {31'd0, to_b}, {31'd0, xb.to});
            chk("b.cycle_cnt", cyc_b, xb.cyc);
            chk("b.retire_cnt", ret_b, xb.ret);
            chk("b.branch_cnt", br_b, xb.br);
            chk("b.mispred_cnt", mp_b, xb.mp);
        end
    end

    logic [9:0] brp, mip;

    initial begin
        brp = 10'b1011011010;
        mip = 10'b1000010100;
        @(posedge clk); #1;
        // no halt: timeouts, then frozen with halt pulses
        repeat (2) step(1, 0, 0, 0, 0);
        for (int j = 1; j <= 235; j++) step(0, 0, rb(2), rb(2), rb(2));
        for (int j = 0; j < 20; j++) step(0, rb(3), rb(2), rb(2), rb(2));
        // halt on 50th RUN cycle of the default instance, retire held
        repeat (2) step(1, 0, 0, 0, 0);
        for (int j = 1; j <= 80; j++) step(0, j == 53 || (j > 60 && rb(4)), 1, rb(2), rb(2));
        // directed branch pattern over 10 RUN cycles, halt/branch during release ignored
        step(1, 0, 0, 0, 0);
        for (int j = 1; j <= 13; j++)
            if (j <= 3) step(0, 1, 1, 1, 1);
            else step(0, j == 13, rb(2), brp[13-j], mip[13-j]);
        repeat (5) step(0, rb(2), 1, 1, 1);
        // halt on the edge the default instance reaches the budget
        repeat (2) step(1, 0, 0, 0, 0);
        for (int j = 1; j <= 210; j++) step(0, j == 203, rb(2), rb(2), rb(2));
        // halt and branch held through the 4-domain release sequence
        step(1, 0, 0, 0, 0);
        for (int j = 1; j <= 60; j++) step(0, j <= 9 || j == 40, rb(2), (j <= 9) ? 1'b1 : rb(2), rb(2));
        // reset pulses mid-SEQ and after 30 RUN cycles
        repeat (2) step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 1, 1, 0);
        step(1, 0, 1, 1, 1);
        for (int j = 1; j <= 33; j++) step(0, 0, rb(2), rb(2), rb(2));
        step(1, 1, 1, 1, 1);
        for (int j = 1; j <= 15; j++) step(0, 0, rb(2), rb(2), rb(2));
        // random runs with occasional resets and halts
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(3, 1)) step(1, rb(2), rb(2), rb(2), rb(2));
            for (int j = 0; j < int'($urandom_range(250, 20)); j++)
                step($urandom_range(99) == 0, rb(64), rb(2), rb(2), rb(2));
        end
        @(negedge clk); #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
